// File: rtl/rst_seq_ctl.sv
// rtl/rst_seq_ctl.sv - Lock-qualified staggered reset release with per-channel software reset holds
module rst_seq_ctl #(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_CYCLES = 16,
  parameter int STEP_CYCLES = 8,
  parameter int HOLD_CYCLES = 4
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            lock_i,
  input  logic [N_CH-1:0] sw_rst_i,
  output logic [N_CH-1:0] rst_n_o,
  output logic            done_o,
  output logic            lock_lost_o
);

  localparam int LW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYCLES - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] CH_FIRST  = (N_CH > 1) ? CW'(1) : CW'(0);

  typedef enum logic [1:0] {
    WAIT_LOCK,
    RELEASE,
    RUN
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  logic [LW-1:0]          lock_cnt_q, lock_cnt_d;
  logic [SW-1:0]          step_cnt_q, step_cnt_d;
  logic [CW-1:0]          ch_q, ch_d;
  logic [HW-1:0]          hold_q [N_CH];
  logic [HW-1:0]          hold_d [N_CH];
  logic [N_CH-1:0]        rst_q, rst_d;
  logic                   done_q, done_d;
  logic                   lost_q, lost_d;

  assign lock_s      = sync_q[SYNC_STAGES-1];
  assign rst_n_o     = rst_q;
  assign done_o      = done_q;
  assign lock_lost_o = lost_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= WAIT_LOCK;
      sync_q     <= '0;
      lock_cnt_q <= '0;
      step_cnt_q <= '0;
      ch_q       <= '0;
      rst_q      <= '0;
      done_q     <= 1'b0;
      lost_q     <= 1'b0;
      for (int k = 0; k < N_CH; k++) hold_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      sync_q     <= {sync_q[SYNC_STAGES-2:0], lock_i};
      lock_cnt_q <= lock_cnt_d;
      step_cnt_q <= step_cnt_d;
      ch_q       <= ch_d;
      rst_q      <= rst_d;
      done_q     <= done_d;
      lost_q     <= lost_d;
      for (int k = 0; k < N_CH; k++) hold_q[k] <= hold_d[k];
    end
  end

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    step_cnt_d = step_cnt_q;
    ch_d       = ch_q;
    rst_d      = rst_q;
    done_d     = done_q;
    lost_d     = lost_q;
    for (int k = 0; k < N_CH; k++) hold_d[k] = hold_q[k];

    unique case (state_q)
      WAIT_LOCK: begin
        rst_d  = '0;
        done_d = 1'b0;
        if (!lock_s) begin
          lock_cnt_d = '0;
        end else if (lock_cnt_q == LOCK_LAST) begin
          lock_cnt_d = '0;
          step_cnt_d = '0;
          rst_d[0]   = 1'b1;
          ch_d       = CH_FIRST;
          if (N_CH == 1) begin
            state_d = RUN;
            done_d  = 1'b1;
          end else begin
            state_d = RELEASE;
          end
        end else begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end
      end

      RELEASE: begin
        if (step_cnt_q == STEP_LAST) begin
          step_cnt_d = '0;
          for (int k = 0; k < N_CH; k++) begin
            if (k == int'(ch_q)) rst_d[k] = 1'b1;
          end
          if (int'(ch_q) == N_CH - 1) begin
            state_d = RUN;
            done_d  = 1'b1;
            ch_d    = '0;
          end else begin
            ch_d = ch_q + 1'b1;
          end
        end else begin
          step_cnt_d = step_cnt_q + 1'b1;
        end
      end

      RUN: begin
        // A low output in RUN always means that channel is in a software hold
        for (int k = 0; k < N_CH; k++) begin
          if (sw_rst_i[k]) begin
            rst_d[k]  = 1'b0;
            hold_d[k] = HOLD_LAST;
          end else if (!rst_q[k]) begin
            if (hold_q[k] == '0) rst_d[k] = 1'b1;
            else hold_d[k] = hold_q[k] - 1'b1;
          end
        end
        done_d = &rst_d;
      end

      default: state_d = WAIT_LOCK;
    endcase

    // Lock loss overrides everything decided above on the same edge
    if (state_q != WAIT_LOCK && !lock_s) begin
      state_d    = WAIT_LOCK;
      lock_cnt_d = '0;
      step_cnt_d = '0;
      ch_d       = '0;
      rst_d      = '0;
      done_d     = 1'b0;
      lost_d     = 1'b1;
      for (int k = 0; k < N_CH; k++) hold_d[k] = '0;
    end
  end

endmodule

// File: tb/tb_rst_seq_ctl.sv
// tb/tb_rst_seq_ctl.sv - Self-checking bench for rst_seq_ctl with a schedule-based reference model
module tb_rst_seq_ctl;

  localparam int N  = 4;
  localparam int S  = 2;
  localparam int L  = 16;
  localparam int ST = 8;
  localparam int H  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         lock;
  logic [N-1:0] sw;
  logic [0:0]   sw1;
  logic [N-1:0] rst_o;
  logic         done_o;
  logic         lost_o;
  logic [0:0]   rst1_o;
  logic         done1_o;
  logic         lost1_o;

  rst_seq_ctl #(
    .N_CH(N), .SYNC_STAGES(S), .LOCK_CYCLES(L), .STEP_CYCLES(ST), .HOLD_CYCLES(H)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .lock_i(lock), .sw_rst_i(sw),
    .rst_n_o(rst_o), .done_o(done_o), .lock_lost_o(lost_o)
  );

  rst_seq_ctl #(
    .N_CH(1), .SYNC_STAGES(S), .LOCK_CYCLES(L), .STEP_CYCLES(ST), .HOLD_CYCLES(H)
  ) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .lock_i(lock), .sw_rst_i(sw1),
    .rst_n_o(rst1_o), .done_o(done1_o), .lock_lost_o(lost1_o)
  );

  // Reference: channel k is up once k*ST edges have elapsed since qualification
  // and the edge count has reached that channel's software-hold deadline.
  bit           m_sync [S];
  bit           m_ls;
  bit           m_seq;
  bit           m_lost;
  int           m_run;
  int           m_t;
  int           m_now = 0;
  int           m_hold_end [N];
  logic [N-1:0] m_rst;
  logic         m_done;

  always @(posedge clk) begin
    m_now++;
    if (!rst_n) begin
      for (int i = 0; i < S; i++) m_sync[i] = 1'b0;
      m_seq = 1'b0; m_lost = 1'b0; m_run = 0; m_t = 0;
      for (int k = 0; k < N; k++) m_hold_end[k] = 0;
    end else begin
      m_ls = m_sync[S-1];
      if (!m_seq) begin
        if (m_ls) begin
          m_run++;
          if (m_run == L) begin m_seq = 1'b1; m_t = 0; m_run = 0; end
        end else begin
          m_run = 0;
        end
      end else if (!m_ls) begin
        m_seq = 1'b0; m_lost = 1'b1; m_run = 0;
        for (int k = 0; k < N; k++) m_hold_end[k] = 0;
      end else begin
        if (m_t >= ST * (N - 1))
          for (int k = 0; k < N; k++) if (sw[k]) m_hold_end[k] = m_now + H;
        m_t++;
      end
      for (int i = S - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
      m_sync[0] = lock;
    end
    for (int k = 0; k < N; k++)
      m_rst[k] = m_seq && (m_t >= ST * k) && (m_now >= m_hold_end[k]);
    m_done = &m_rst;
  end

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (chk_on) begin
      total++;
      if ({rst_o, done_o, lost_o} !== {m_rst, m_done, m_lost}) begin
        bad++;
        $display("FAIL model t=%0t: got rst=%b done=%b lost=%b want rst=%b done=%b lost=%b",
                 $time, rst_o, done_o, lost_o, m_rst, m_done, m_lost);
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; lock = 1'b0; sw = '0;
    tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    int g;
    int n;
    int rise0;
    int lost;
  } vec_t;

  vec_t         tbl [6];
  logic [N-1:0] p;
  logic         pd, pd1;
  logic [0:0]   p1;
  int           r0, r1, r3, dn, r0_1, dn_1, drop;

  initial begin
    rst_n = 1'b0; lock = 1'b0; sw = '0; sw1 = '0;
    tick(); tick();
    chk_on = 1'b1;
    chk("reset_rst", rst_o, 0);
    chk("reset_done", done_o, 0);
    chk("reset_lost", lost_o, 0);

    // {glitch start edge, glitch length, last rise edge of ch0, lock_lost}
    tbl[0] = '{0, 0, 17, 0};
    tbl[1] = '{10, 1, 28, 0};
    tbl[2] = '{3, 2, 22, 0};
    tbl[3] = '{15, 1, 33, 0};
    tbl[4] = '{16, 1, 34, 1};
    tbl[5] = '{5, 4, 26, 0};
    for (int i = 0; i < 6; i++) begin
      do_reset();
      p = rst_o; pd = done_o; r0 = -1; r3 = -1; dn = -1;
      for (int e = 0; e < 80; e++) begin
        lock = !(e >= tbl[i].g && e < tbl[i].g + tbl[i].n);
        tick();
        if (!p[0] && rst_o[0]) r0 = e;
        if (!p[3] && rst_o[3]) r3 = e;
        if (!pd && done_o) dn = e;
        p = rst_o; pd = done_o;
      end
      chk("tbl_rise0", r0, tbl[i].rise0);
      chk("tbl_rise3", r3, tbl[i].rise0 + 24);
      chk("tbl_done", dn, tbl[i].rise0 + 24);
      chk("tbl_lost", lost_o, tbl[i].lost);
    end

    // Lock drops mid-release, then returns
    do_reset();
    p = rst_o; pd = done_o; r0 = -1; dn = -1;
    for (int e = 0; e < 80; e++) begin
      lock = (e < 30 || e >= 33);
      tick();
      if (e == 31) chk("drop_e31_rst", rst_o, 4'b0011);
      if (e == 32) begin
        chk("drop_e32_rst", rst_o, 0);
        chk("drop_e32_done", done_o, 0);
        chk("drop_e32_lost", lost_o, 1);
      end
      if (!p[0] && rst_o[0]) r0 = e;
      if (!pd && done_o) dn = e;
      p = rst_o; pd = done_o;
    end
    chk("relock_rise0", r0, 50);
    chk("relock_done", dn, 74);
    chk("relock_lost", lost_o, 1);

    // Software hold and retrigger in RUN
    tick(); tick();
    sw = 4'b0100; tick(); sw = '0;
    chk("sw_es", {rst_o, done_o}, 5'b10110);
    for (int j = 1; j < 4; j++) begin
      tick();
      chk("sw_hold", {rst_o, done_o}, 5'b10110);
    end
    tick();
    chk("sw_release", {rst_o, done_o}, 5'b11111);
    tick();
    sw = 4'b0100; tick(); sw = '0;
    tick();
    sw = 4'b0100; tick(); sw = '0;
    for (int j = 3; j < 6; j++) begin
      tick();
      chk("retrig_hold", {rst_o, done_o}, 5'b10110);
    end
    tick();
    chk("retrig_release", {rst_o, done_o}, 5'b11111);

    // Software request on the same edge as lock loss
    lock = 1'b0;
    tick();
    tick();
    chk("loss_pre", rst_o, 4'b1111);
    sw = 4'b0010;
    tick();
    sw = '0;
    chk("loss_sw_rst", rst_o, 0);
    chk("loss_sw_done", done_o, 0);
    chk("loss_sw_lost", lost_o, 1);
    lock = 1'b1;
    p = rst_o; pd = done_o; r0 = -1; r1 = -1; dn = -1;
    for (int e = 0; e < 45; e++) begin
      tick();
      if (!p[0] && rst_o[0]) r0 = e;
      if (!p[1] && rst_o[1]) r1 = e;
      if (!pd && done_o) dn = e;
      p = rst_o; pd = done_o;
    end
    chk("loss_sw_rise0", r0, 17);
    chk("loss_sw_rise1", r1, 25);
    chk("loss_sw_done_rise", dn, 41);
    chk("n1_lost_before", lost1_o, 1);
    chk("n1_run_before", {rst1_o, done1_o}, 2'b11);

    // One-edge reset in RUN with lock_lost set
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_run_outs", {rst_o, done_o, lost_o}, 0);
    chk("rst_run_n1", {rst1_o, done1_o, lost1_o}, 0);
    p = rst_o; p1 = rst1_o; pd1 = done1_o; r0 = -1; r0_1 = -1; dn_1 = -1;
    for (int e = 0; e < 20; e++) begin
      tick();
      if (!p[0] && rst_o[0]) r0 = e;
      if (!p1[0] && rst1_o[0]) r0_1 = e;
      if (!pd1 && done1_o) dn_1 = e;
      p = rst_o; p1 = rst1_o; pd1 = done1_o;
    end
    chk("rst_requal_rise0", r0, 17);
    chk("n1_rise0", r0_1, 17);
    chk("n1_done", dn_1, 17);

    // Randomised traffic against the reference model
    drop = 0;
    for (int c = 0; c < 3000; c++) begin
      if (drop > 0) begin
        lock = 1'b0;
        drop--;
      end else begin
        lock = 1'b1;
        if ($urandom_range(0, 199) == 0) drop = $urandom_range(1, 6);
      end
      sw = N'($urandom) & N'($urandom) & N'($urandom);
      rst_n = ($urandom_range(0, 999) != 0);
      tick();
    end
    rst_n = 1'b1;
    sw = '0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rst_seq_ctl.md
# rst_seq_ctl

Parametrised reset sequencer for the system control path. It watches a PLL lock indication and qualifies it over a stable window. It then releases `N_CH` reset outputs one at a time at a fixed spacing, re-asserts all of them on loss of lock, and supports per-channel software reset pulses. Its outputs feed the per-domain reset synchronisers downstream.

## Interface
Parameters:
- `N_CH`, 4, number of sequenced reset channels (≥1)
- `SYNC_STAGES`, 2, flops in the `lock_i` synchroniser (≥2)
- `LOCK_CYCLES`, 16, consecutive synchronised-lock cycles needed before release (≥1)
- `STEP_CYCLES`, 8, cycles between successive channel releases (≥1)
- `HOLD_CYCLES`, 4, low duration of a software channel reset (≥1)

Ports:
- `clk_i` in 1: single clock, all logic rising-edge
- `rst_n_i` in 1: reset; one clock; reset is synchronous and active-low
- `lock_i` in 1: PLL locked, asynchronous to `clk_i`
- `sw_rst_i` in `N_CH`: per-channel software reset request, level-sampled each edge
- `rst_n_o` out `N_CH`: sequenced active-low resets, registered
- `done_o` out 1: all channels released and none in software hold, registered
- `lock_lost_o` out 1: sticky flag, lock dropped after release began

## Operation
- Synchroniser: `SYNC_STAGES` flops, all reset to 0. `lock_s` is the last stage.
- States:
  - WAIT_LOCK (reset state): all `rst_n_o`=0; `lock_cnt` increments on each edge with `lock_s`=1 and clears to 0 on any edge with `lock_s`=0. On an edge where `lock_s`=1 and `lock_cnt`==LOCK_CYCLES-1, set `rst_n_o[0]`=1, clear `step_cnt`, `ch`=1, go RELEASE (go RUN directly if N_CH==1, `done_o`=1 same edge).
  - RELEASE: `step_cnt` increments each edge. When `step_cnt`==STEP_CYCLES-1, set `rst_n_o[ch]`=1, clear `step_cnt`, `ch`++. Releasing channel N_CH-1 goes RUN and sets `done_o`=1 on the same edge. `sw_rst_i` is ignored.
  - RUN: `sw_rst_i[k]`=1 on an edge sets `rst_n_o[k]`=0 and loads `hold_cnt[k]`=HOLD_CYCLES-1.
    - Each following edge decrements the counter. On the edge where it reads 0, `rst_n_o[k]`=1.
    - A new request during the hold reloads the counter (retrigger).
    - `done_o` = 1 iff no channel is in hold, registered with `rst_n_o`.
- Lock loss: `lock_s`=0 sampled in RELEASE or RUN sets all `rst_n_o`=0, `done_o`=0, `lock_lost_o`=1 and clears all counters and holds on that edge, then goes to WAIT_LOCK. Lock loss has priority over simultaneous software requests and step completion.
- `lock_lost_o` clears only on `rst_n_i`=0.
- Counter widths are `$clog2(max value+1)`, with a minimum of 1. Counters never wrap: each is compared and reloaded before it overflows.

## Timing
- Reset values: `rst_n_o`=0 (all bits), `done_o`=0, `lock_lost_o`=0, synchroniser=0, state=WAIT_LOCK, all counters=0. Reset takes effect on the first edge with `rst_n_i`=0, including mid-sequence or mid-hold.
- Edge numbering: E0 is the first edge sampling `lock_i`=1, and `lock_i` stays high.
  - `lock_s`=1 after E(SYNC_STAGES-1).
  - `rst_n_o[0]` rises after E(SYNC_STAGES+LOCK_CYCLES-1).
  - `rst_n_o[k]` rises STEP_CYCLES·k edges later.
  - `done_o` rises with `rst_n_o[N_CH-1]`.
- Lock-loss latency: if `lock_i` is first sampled 0 at E0, all outputs are low after E(SYNC_STAGES).
- A software reset sampled at Es gives `rst_n_o[k]` low after Es and high after Es+HOLD_CYCLES, i.e. exactly HOLD_CYCLES cycles low. Other channels are unaffected.
- All outputs change only on `clk_i` rising edges; there are no combinational paths from inputs to outputs.

## Test plan
- Defaults, `lock_i` high from E0 → `rst_n_o[0..3]` rise after E17, E25, E33, E41; `done_o` rises after E41; `lock_lost_o`=0.
- `lock_i` pulses low for 1 cycle at E10 of the lock window → counter restarts; `rst_n_o[0]` rises 16 edges after `lock_s` returns high; `lock_lost_o` stays 0.
- `lock_i` drops at E30 (mid-release) → all `rst_n_o`=0 and `done_o`=0 after E32, `lock_lost_o`=1. Lock restored → full sequence repeats; `lock_lost_o` stays 1.
- In RUN, `sw_rst_i`=4'b0100 for one cycle at Es → `rst_n_o[2]` low for exactly 4 cycles, `done_o` low for the same 4 cycles. A second pulse at Es+2 extends the low time to Es+6.
- `sw_rst_i[1]` and a lock-loss edge coincide → all channels low, no hold remains active, sequence restarts from WAIT_LOCK.
- `rst_n_i`=0 for one edge while in RUN with `lock_lost_o`=1 → all outputs return to reset values on that edge; with `lock_i` high, the sequence restarts with 16-cycle qualification (N_CH=1 variant: `done_o` rises with `rst_n_o[0]`).
